// File: rtl/color_sense_ctrl.sv
// Colour-sensor controller: steps the R/G/B/clear filters, averages the sensor
// output period on each channel and classifies the dominant colour once per frame.
module color_sense_ctrl #(
  parameter int         CNT_W       = 16,
  parameter int         AVG_SHIFT   = 2,
  parameter int         SETTLE_CYC  = 1000,
  parameter int         TIMEOUT_CYC = 60000,
  parameter int         WHITE_MIN   = 80,
  parameter int         WHITE_MAX   = 250,
  parameter logic [1:0] FREQ_SCALE  = 2'b10
) (
  input  logic             scaled_clock,
  input  logic             reset_n,
  input  logic             en,
  input  logic             cs_output,
  output logic             cs_S0,
  output logic             cs_S1,
  output logic             cs_S2,
  output logic             cs_S3,
  output logic             cs_en,
  output logic [CNT_W-1:0] red,
  output logic [CNT_W-1:0] green,
  output logic [CNT_W-1:0] blue,
  output logic [CNT_W-1:0] white,
  output logic [1:0]       cd_out,
  output logic             result_valid,
  output logic             timeout
);

  localparam int               ACC_W       = CNT_W + AVG_SHIFT;
  localparam int               KW          = AVG_SHIFT + 1;
  localparam logic [KW-1:0]    K_FULL      = KW'(1 << AVG_SHIFT);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] W_MIN       = CNT_W'(WHITE_MIN);
  localparam logic [CNT_W-1:0] W_MAX       = CNT_W'(WHITE_MAX);
  localparam logic [1:0]       CH_R        = 2'd0;
  localparam logic [1:0]       CH_W        = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_ALIGN, S_MEASURE, S_STORE, S_DECIDE
  } state_t;

  state_t             state_reg;
  logic [1:0]         ch_reg;
  logic [1:0]         filt_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [ACC_W-1:0]   acc_reg;
  logic [KW-1:0]      k_reg;
  logic               ch_to_reg;
  logic               frame_to_reg;
  logic [2:0]         sync_reg;

  logic               edge_det;
  logic [CNT_W-1:0]   cnt_inc;
  logic [KW-1:0]      k_next;
  logic               to_hit;
  logic               meas_we;
  logic [CNT_W-1:0]   meas_wdata;
  logic [CNT_W-1:0]   r_val, g_val, b_val, w_val;
  logic [1:0]         cd_next;

  function automatic logic [1:0] filter_code(input logic [1:0] ch);
    case (ch)
      2'd0:    filter_code = 2'b00;
      2'd1:    filter_code = 2'b11;
      2'd2:    filter_code = 2'b01;
      default: filter_code = 2'b10;
    endcase
  endfunction

  assign {cs_S0, cs_S1} = FREQ_SCALE;
  assign {cs_S2, cs_S3} = filt_reg;

  // sync_reg[1:0] is the two-flop synchroniser, sync_reg[2] its delayed copy
  assign edge_det = sync_reg[1] & ~sync_reg[2];
  assign cnt_inc  = (cnt_reg == {CNT_W{1'b1}}) ? cnt_reg : cnt_reg + CNT_W'(1);
  assign k_next   = k_reg + KW'(1);
  assign to_hit   = en && (state_reg == S_ALIGN || state_reg == S_MEASURE)
                    && (cnt_reg == TIMEOUT_VAL);

  // A timed-out channel is written with all ones immediately; STORE then skips it
  assign meas_we    = to_hit || (state_reg == S_STORE && !ch_to_reg);
  assign meas_wdata = to_hit ? {CNT_W{1'b1}} : CNT_W'(acc_reg >> AVG_SHIFT);

  // Working copies of this frame's channel periods; published only at DECIDE
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_meas
      logic [CNT_W-1:0] val_reg;
      always_ff @(posedge scaled_clock or negedge reset_n) begin
        if (!reset_n)
          val_reg <= '0;
        else if (meas_we && ch_reg == 2'(gi))
          val_reg <= meas_wdata;
      end
    end
  endgenerate

  assign r_val = g_meas[0].val_reg;
  assign g_val = g_meas[1].val_reg;
  assign b_val = g_meas[2].val_reg;
  assign w_val = g_meas[3].val_reg;

  always_comb begin
    cd_next = 2'b11;
    if (!(w_val < W_MIN || w_val > W_MAX || frame_to_reg)) begin
      if (r_val < g_val && r_val < b_val)
        cd_next = 2'b00;
      else if (g_val < r_val && g_val < b_val)
        cd_next = 2'b01;
      else if (b_val < r_val && b_val < g_val)
        cd_next = 2'b10;
    end
  end

  always_ff @(posedge scaled_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= S_IDLE;
      ch_reg       <= CH_R;
      filt_reg     <= 2'b00;
      cnt_reg      <= '0;
      acc_reg      <= '0;
      k_reg        <= '0;
      ch_to_reg    <= 1'b0;
      frame_to_reg <= 1'b0;
      sync_reg     <= '0;
      cs_en        <= 1'b1;
      red          <= '0;
      green        <= '0;
      blue         <= '0;
      white        <= '0;
      cd_out       <= 2'b11;
      result_valid <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      sync_reg     <= {sync_reg[1:0], cs_output};
      cs_en        <= ~en;
      result_valid <= 1'b0;

      if (!en && state_reg != S_IDLE && state_reg != S_DECIDE) begin
        state_reg <= S_IDLE;
        ch_to_reg <= 1'b0;
      end else begin
        case (state_reg)
          S_IDLE: begin
            if (en) begin
              state_reg    <= S_SELECT;
              ch_reg       <= CH_R;
              filt_reg     <= filter_code(CH_R);
              cnt_reg      <= '0;
              frame_to_reg <= 1'b0;
            end
          end

          S_SELECT: begin
            if (cnt_reg == SETTLE_LAST) begin
              state_reg <= S_ALIGN;
              cnt_reg   <= '0;
            end else begin
              cnt_reg <= cnt_inc;
            end
          end

          S_ALIGN: begin
            if (to_hit) begin
              ch_to_reg    <= 1'b1;
              frame_to_reg <= 1'b1;
              state_reg    <= S_STORE;
            end else if (edge_det) begin
              cnt_reg   <= '0;
              acc_reg   <= '0;
              k_reg     <= '0;
              state_reg <= S_MEASURE;
            end else begin
              cnt_reg <= cnt_inc;
            end
          end

          S_MEASURE: begin
            if (to_hit) begin
              ch_to_reg    <= 1'b1;
              frame_to_reg <= 1'b1;
              state_reg    <= S_STORE;
            end else if (edge_det) begin
              // period includes the edge cycle itself
              acc_reg <= acc_reg + ACC_W'(cnt_reg) + ACC_W'(1);
              cnt_reg <= '0;
              k_reg   <= k_next;
              if (k_next == K_FULL)
                state_reg <= S_STORE;
            end else begin
              cnt_reg <= cnt_inc;
            end
          end

          S_STORE: begin
            ch_to_reg <= 1'b0;
            if (ch_reg == CH_W) begin
              state_reg <= S_DECIDE;
            end else begin
              ch_reg    <= ch_reg + 2'd1;
              filt_reg  <= filter_code(ch_reg + 2'd1);
              cnt_reg   <= '0;
              state_reg <= S_SELECT;
            end
          end

          S_DECIDE: begin
            red          <= r_val;
            green        <= g_val;
            blue         <= b_val;
            white        <= w_val;
            cd_out       <= cd_next;
            timeout      <= frame_to_reg;
            result_valid <= 1'b1;
            if (en) begin
              state_reg    <= S_SELECT;
              ch_reg       <= CH_R;
              filt_reg     <= filter_code(CH_R);
              cnt_reg      <= '0;
              frame_to_reg <= 1'b0;
            end else begin
              state_reg <= S_IDLE;
            end
          end

          default: state_reg <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_color_sense_ctrl.sv
// Directed bench: a sensor model produces per-filter periods and each frame's
// published result is checked against hand-computed values.
module tb_color_sense_ctrl;

  logic        scaled_clock = 1'b0;
  logic        reset_n      = 1'b1;
  logic        en           = 1'b0;
  logic        cs_output    = 1'b0;
  logic        cs_S0, cs_S1, cs_S2, cs_S3, cs_en;
  logic [15:0] red, green, blue, white;
  logic [1:0]  cd_out;
  logic        result_valid, timeout;

  int          total = 0;
  int          bad   = 0;
  int          per [4][4];
  bit          stop_b = 1'b0;
  logic [1:0]  gen_code = 2'b00;
  int          gen_cnt = 0;
  int          gen_j = 0;
  int          gen_p = 0;
  logic [1:0]  seq [8];
  int          nseq = 0;
  bit          found = 1'b0;
  int          frame_no = 0;
  int          pulses = 0;

  color_sense_ctrl #(
    .CNT_W       (16),
    .AVG_SHIFT   (2),
    .SETTLE_CYC  (16),
    .TIMEOUT_CYC (1000),
    .WHITE_MIN   (80),
    .WHITE_MAX   (250),
    .FREQ_SCALE  (2'b10)
  ) dut (
    .scaled_clock (scaled_clock),
    .reset_n      (reset_n),
    .en           (en),
    .cs_output    (cs_output),
    .cs_S0        (cs_S0),
    .cs_S1        (cs_S1),
    .cs_S2        (cs_S2),
    .cs_S3        (cs_S3),
    .cs_en        (cs_en),
    .red          (red),
    .green        (green),
    .blue         (blue),
    .white        (white),
    .cd_out       (cd_out),
    .result_valid (result_valid),
    .timeout      (timeout)
  );

  always #5 scaled_clock = ~scaled_clock;

  function automatic int chan_of(input logic [1:0] c);
    case (c)
      2'b00:   return 0;
      2'b11:   return 1;
      2'b01:   return 2;
      default: return 3;
    endcase
  endfunction

  // Sensor model: restarts its waveform whenever the filter select changes
  always @(negedge scaled_clock) begin
    if ({cs_S2, cs_S3} != gen_code) begin
      gen_code = {cs_S2, cs_S3};
      gen_cnt  = 0;
      gen_j    = 0;
    end else begin
      gen_p = per[chan_of(gen_code)][gen_j];
      gen_cnt++;
      if (gen_cnt >= gen_p) begin
        gen_cnt = 0;
        gen_j   = (gen_j + 1) % 4;
      end
    end
    gen_p     = per[chan_of(gen_code)][gen_j];
    cs_output = (stop_b && gen_code == 2'b01) ? 1'b0 : (gen_cnt < gen_p / 2);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_periods(input int r, input int g, input int b, input int w);
    for (int j = 0; j < 4; j++) begin
      per[0][j] = r;
      per[1][j] = g;
      per[2][j] = b;
      per[3][j] = w;
    end
  endtask

  task automatic wait_frame(input int budget, input string tag);
    logic [1:0] last;
    found   = 1'b0;
    last    = {cs_S2, cs_S3};
    seq[0]  = last;
    nseq    = 1;
    for (int i = 0; i < budget && !found; i++) begin
      @(posedge scaled_clock);
      #1;
      if (result_valid) begin
        found = 1'b1;
      end else if ({cs_S2, cs_S3} != last) begin
        last = {cs_S2, cs_S3};
        if (nseq < 8) seq[nseq] = last;
        nseq++;
      end
    end
    total++;
    assert (found) else begin
      bad++;
      $error("FAIL %s_frame: observed=no result_valid expected=result_valid within %0d cycles",
             tag, budget);
    end
    frame_no++;
    $display("frame %0d %s: red=%0d green=%0d blue=%0d white=%0d cd_out=%0d timeout=%0b",
             frame_no, tag, red, green, blue, white, cd_out, timeout);
  endtask

  initial begin
    set_periods(100, 180, 200, 120);

    // Reset held with the sensor toggling
    reset_n = 1'b0;
    repeat (120) @(posedge scaled_clock);
    #1;
    check("rst_cs_en",  32'(cs_en), 32'd1);
    check("rst_cd_out", 32'(cd_out), 32'd3);
    check("rst_valid",  32'(result_valid), 32'd0);
    check("rst_s2s3",   32'({cs_S2, cs_S3}), 32'd0);
    check("rst_s0s1",   32'({cs_S0, cs_S1}), 32'd2);
    check("rst_red",    32'(red), 32'd0);
    check("rst_tmo",    32'(timeout), 32'd0);

    @(negedge scaled_clock);
    reset_n = 1'b1;
    en      = 1'b1;
    @(posedge scaled_clock);
    #1;
    check("run_cs_en", 32'(cs_en), 32'd0);

    // Red dominant
    wait_frame(8000, "red_dom");
    check("rd_red",   32'(red),   32'd100);
    check("rd_green", 32'(green), 32'd180);
    check("rd_blue",  32'(blue),  32'd200);
    check("rd_white", 32'(white), 32'd120);
    check("rd_cd",    32'(cd_out), 32'd0);
    check("rd_tmo",   32'(timeout), 32'd0);

    // Jitter on red; also the filter order within one frame
    per[0][0] = 98; per[0][1] = 102; per[0][2] = 99; per[0][3] = 101;
    @(posedge scaled_clock);
    #1;
    check("valid_one_cycle", 32'(result_valid), 32'd0);
    wait_frame(8000, "jitter");
    check("jit_red",  32'(red), 32'd100);
    check("jit_cd",   32'(cd_out), 32'd0);
    check("jit_nseq", 32'(nseq), 32'd4);
    check("jit_order", 32'({seq[0], seq[1], seq[2], seq[3]}), 32'b00_11_01_10);

    // White out of range high, low, then on the lower boundary
    set_periods(180, 100, 200, 300);
    wait_frame(8000, "white_hi");
    check("wh_cd",    32'(cd_out), 32'd3);
    check("wh_tmo",   32'(timeout), 32'd0);
    check("wh_white", 32'(white), 32'd300);
    check("wh_green", 32'(green), 32'd100);

    set_periods(180, 100, 200, 79);
    wait_frame(8000, "white_lo");
    check("wl_cd",    32'(cd_out), 32'd3);
    check("wl_white", 32'(white), 32'd79);

    set_periods(180, 100, 200, 80);
    wait_frame(8000, "white_min");
    check("wm_cd",    32'(cd_out), 32'd1);
    check("wm_white", 32'(white), 32'd80);

    // Blue channel starved of edges
    set_periods(100, 180, 200, 120);
    stop_b = 1'b1;
    wait_frame(8000, "timeout");
    check("to_blue", 32'(blue), 32'h0000ffff);
    check("to_tmo",  32'(timeout), 32'd1);
    check("to_cd",   32'(cd_out), 32'd3);
    check("to_red",  32'(red), 32'd100);

    stop_b = 1'b0;
    wait_frame(8000, "recover");
    check("rc_tmo",  32'(timeout), 32'd0);
    check("rc_blue", 32'(blue), 32'd200);
    check("rc_cd",   32'(cd_out), 32'd0);

    // Abort during the green channel
    found = 1'b0;
    for (int i = 0; i < 4000 && !found; i++) begin
      @(posedge scaled_clock);
      #1;
      if ({cs_S2, cs_S3} == 2'b11) found = 1'b1;
    end
    check("ab_reach_green", 32'(found), 32'd1);
    repeat (50) @(posedge scaled_clock);
    #1;
    en = 1'b0;
    @(posedge scaled_clock);
    #1;
    check("ab_cs_en", 32'(cs_en), 32'd1);
    check("ab_valid", 32'(result_valid), 32'd0);
    check("ab_red",   32'(red), 32'd100);
    check("ab_blue",  32'(blue), 32'd200);
    check("ab_cd",    32'(cd_out), 32'd0);
    pulses = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge scaled_clock);
      #1;
      if (result_valid) pulses++;
    end
    check("ab_no_pulse", 32'(pulses), 32'd0);
    check("ab_green_held", 32'(green), 32'd180);

    // Tie for minimum after restarting
    set_periods(150, 150, 200, 120);
    en = 1'b1;
    wait_frame(8000, "tie");
    check("tie_cd",    32'(cd_out), 32'd3);
    check("tie_red",   32'(red), 32'd150);
    check("tie_green", 32'(green), 32'd150);
    check("tie_tmo",   32'(timeout), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
